// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 32-bit LFSR random-word generator.
// It self-synchronises to the incoming stream of LFSR state words. Once locked,
// it predicts each following word and counts word and bit errors.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous reset, active-low
//   i_data_in        received LFSR state word
//   i_data_valid     qualifier for i_data_in; a word is consumed only when 1
//   i_clear_cnt      synchronous clear of the three statistics counters
//   o_locked         1 while the FSM is in LOCKED
//   o_err_pulse      one-cycle strobe for each mismatched word seen in LOCKED
//   o_err_count      mismatched words since the last clear (saturating)
//   o_bit_err_count  mismatched bits since the last clear (saturating)
//   o_word_count     words checked in LOCKED since the last clear (saturating)
module prbs_checker #(
  parameter logic [31:0] POLY       = 32'h80200003,
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_data_in,
  input  logic             i_data_valid,
  input  logic             i_clear_cnt,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_bit_err_count,
  output logic [CNT_W-1:0] o_word_count
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW  = $clog2(LOSS_COUNT + 1);
  // Wide enough to hold the counter plus one word's popcount (up to 32).
  localparam int unsigned SumW   = CNT_W + 6;

  localparam logic [MatchW-1:0] LockLast = MatchW'(LOCK_COUNT - 1);
  localparam logic [MissW-1:0]  LossLast = MissW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & POLY)};
  endfunction

  state_e            r_state;
  logic [31:0]       r_expected;
  logic [MatchW-1:0] r_match_cnt;
  logic [MissW-1:0]  r_miss_cnt;
  logic              r_locked;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_count;
  logic [CNT_W-1:0]  r_bit_err_count;
  logic [CNT_W-1:0]  r_word_count;

  logic [31:0]       w_step_in;
  logic [31:0]       w_step_exp;
  logic              w_match;
  logic              w_nonzero;
  logic [5:0]        w_popcnt;
  logic [SumW-1:0]   w_bit_sum;
  logic [CNT_W-1:0]  w_bit_next;
  logic              w_check;

  always_comb begin
    w_step_in  = lfsr_step(i_data_in);
    w_step_exp = lfsr_step(r_expected);
    w_match    = (i_data_in == r_expected);
    w_nonzero  = (i_data_in != 32'h0);
    w_popcnt   = 6'($countones(i_data_in ^ r_expected));
    w_bit_sum  = SumW'(r_bit_err_count) + SumW'(w_popcnt);
    // Clamp when the addition overflows the counter width.
    w_bit_next = (w_bit_sum[SumW-1:CNT_W] != '0) ? '1 : w_bit_sum[CNT_W-1:0];
    w_check    = i_data_valid && (r_state == StLocked);
  end

  // Synchronisation FSM and predictor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StHunt;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (i_data_valid) begin
        case (r_state)
          StHunt: begin
            // An all-zero word is not a legal LFSR state and cannot seed.
            if (w_nonzero) begin
              r_expected  <= w_step_in;
              r_match_cnt <= '0;
              r_state     <= StSync;
            end
          end
          StSync: begin
            if (w_match) begin
              r_expected  <= w_step_in;
              r_match_cnt <= r_match_cnt + MatchW'(1);
              if (r_match_cnt == LockLast) begin
                r_state    <= StLocked;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else begin
              r_match_cnt <= '0;
              if (w_nonzero) begin
                r_expected <= w_step_in;
              end else begin
                r_state <= StHunt;
              end
            end
          end
          StLocked: begin
            // Free-running predictor: a corrupted word never reseeds it.
            r_expected <= w_step_exp;
            if (w_match) begin
              r_miss_cnt <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              if (r_miss_cnt == LossLast) begin
                r_state     <= StHunt;
                r_locked    <= 1'b0;
                r_miss_cnt  <= '0;
                r_match_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + MissW'(1);
              end
            end
          end
          default: begin
            r_state  <= StHunt;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics counters. Clear wins over a coincident increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count     <= '0;
      r_bit_err_count <= '0;
      r_word_count    <= '0;
    end else if (i_clear_cnt) begin
      r_err_count     <= '0;
      r_bit_err_count <= '0;
      r_word_count    <= '0;
    end else if (w_check) begin
      if (r_word_count != '1) begin
        r_word_count <= r_word_count + CNT_W'(1);
      end
      if (!w_match) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        r_bit_err_count <= w_bit_next;
      end
    end
  end

  assign o_locked        = r_locked;
  assign o_err_pulse     = r_err_pulse;
  assign o_err_count     = r_err_count;
  assign o_bit_err_count = r_bit_err_count;
  assign o_word_count    = r_word_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. Drives one shared stream into a default
// build (CNT_W=16) and a narrow build (CNT_W=4) and checks lock timing,
// error counting, gap handling, reset and counter saturation.
module tb_prbs_checker;

  localparam logic [31:0] Poly = 32'h80200003;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        clear_cnt;

  logic        locked_a;
  logic        err_pulse_a;
  logic [15:0] err_count_a;
  logic [15:0] bit_err_count_a;
  logic [15:0] word_count_a;

  logic        locked_b;
  logic        err_pulse_b;
  logic [3:0]  err_count_b;
  logic [3:0]  bit_err_count_b;
  logic [3:0]  word_count_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] gen;

  prbs_checker #(.CNT_W(16)) u_dut_a (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_data_in       (data_in),
    .i_data_valid    (data_valid),
    .i_clear_cnt     (clear_cnt),
    .o_locked        (locked_a),
    .o_err_pulse     (err_pulse_a),
    .o_err_count     (err_count_a),
    .o_bit_err_count (bit_err_count_a),
    .o_word_count    (word_count_a)
  );

  prbs_checker #(.CNT_W(4)) u_dut_b (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_data_in       (data_in),
    .i_data_valid    (data_valid),
    .i_clear_cnt     (clear_cnt),
    .o_locked        (locked_b),
    .o_err_pulse     (err_pulse_b),
    .o_err_count     (err_count_b),
    .o_bit_err_count (bit_err_count_b),
    .o_word_count    (word_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & Poly)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, then sample 1 time unit after the edge.
  task automatic push(input logic [31:0] d, input logic v, input logic clr);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    clear_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean();
    push(gen, 1'b1, 1'b0);
    gen = lfsr_step(gen);
  endtask

  task automatic send_bad(input logic [31:0] mask);
    push(gen ^ mask, 1'b1, 1'b0);
    gen = lfsr_step(gen);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    clear_cnt  = 1'b0;
    gen        = 32'h12345678;

    // Reset state
    #1;
    chk("reset_locked", {31'b0, locked_a}, 0);
    chk("reset_err_pulse", {31'b0, err_pulse_a}, 0);
    chk("reset_err_count", {16'b0, err_count_a}, 0);
    chk("reset_bit_err", {16'b0, bit_err_count_a}, 0);
    chk("reset_word_count", {16'b0, word_count_a}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: clean stream locks on the 9th valid word
    for (int i = 0; i < 8; i++) send_clean();
    chk("t1_not_locked_after_8", {31'b0, locked_a}, 0);
    send_clean();
    chk("t1_locked_after_9", {31'b0, locked_a}, 1);
    chk("t1_err_count", {16'b0, err_count_a}, 0);
    chk("t1_word_count_at_lock", {16'b0, word_count_a}, 0);
    send_clean();
    send_clean();
    chk("t1_word_count_incr", {16'b0, word_count_a}, 2);

    // 2: single-bit error
    send_bad(32'h00000001);
    chk("t2_err_pulse_hi", {31'b0, err_pulse_a}, 1);
    chk("t2_err_count", {16'b0, err_count_a}, 1);
    chk("t2_bit_err", {16'b0, bit_err_count_a}, 1);
    chk("t2_locked", {31'b0, locked_a}, 1);
    chk("t2_word_count", {16'b0, word_count_a}, 3);
    send_clean();
    chk("t2_err_pulse_lo", {31'b0, err_pulse_a}, 0);
    chk("t2_err_count_hold", {16'b0, err_count_a}, 1);
    chk("t2_locked_hold", {31'b0, locked_a}, 1);

    // 3: clear, then 4 bad words lose lock; relock after 9 clean words
    push(32'h0, 1'b0, 1'b1);
    chk("t3_cleared", {16'b0, err_count_a}, 0);
    chk("t3_locked_after_clear", {31'b0, locked_a}, 1);
    for (int i = 0; i < 3; i++) send_bad(32'hFFFF0000);
    chk("t3_locked_after_3_bad", {31'b0, locked_a}, 1);
    send_bad(32'hFFFF0000);
    chk("t3_unlocked_after_4_bad", {31'b0, locked_a}, 0);
    chk("t3_err_count", {16'b0, err_count_a}, 4);
    chk("t3_bit_err", {16'b0, bit_err_count_a}, 64);
    chk("t3_word_count", {16'b0, word_count_a}, 4);
    for (int i = 0; i < 8; i++) send_clean();
    chk("t3_not_relocked_after_8", {31'b0, locked_a}, 0);
    send_clean();
    chk("t3_relocked_after_9", {31'b0, locked_a}, 1);
    chk("t3_err_count_kept", {16'b0, err_count_a}, 4);

    // 4: drop to HUNT, zeros are ignored, relock 9 words after first nonzero
    for (int i = 0; i < 4; i++) send_bad(32'hFFFF0000);
    chk("t4_unlocked", {31'b0, locked_a}, 0);
    for (int i = 0; i < 5; i++) push(32'h0, 1'b1, 1'b0);
    chk("t4_hunt_on_zeros", {31'b0, locked_a}, 0);
    chk("t4_no_err_on_zeros", {16'b0, err_count_a}, 8);
    for (int i = 0; i < 8; i++) send_clean();
    chk("t4_not_locked_after_8", {31'b0, locked_a}, 0);
    send_clean();
    chk("t4_locked_after_9", {31'b0, locked_a}, 1);

    // 5: gaps with junk on data_in, then async reset mid-stream
    for (int i = 0; i < 6; i++) begin
      send_clean();
      push(32'hDEADBEEF, 1'b0, 1'b0);
      chk("t5_gap_err_pulse", {31'b0, err_pulse_a}, 0);
    end
    chk("t5_locked", {31'b0, locked_a}, 1);
    chk("t5_err_count", {16'b0, err_count_a}, 8);
    chk("t5_bit_err", {16'b0, bit_err_count_a}, 128);
    chk("t5_word_count", {16'b0, word_count_a}, 14);
    send_bad(32'h00000001);
    @(negedge clk);
    data_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("t5_rst_locked", {31'b0, locked_a}, 0);
    chk("t5_rst_err_pulse", {31'b0, err_pulse_a}, 0);
    chk("t5_rst_err_count", {16'b0, err_count_a}, 0);
    chk("t5_rst_bit_err", {16'b0, bit_err_count_a}, 0);
    chk("t5_rst_word_count", {16'b0, word_count_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_clean();
    chk("t5_hunt_after_reset", {31'b0, locked_a}, 0);

    // 6: 20 bad words with relocks; narrow build saturates at 15
    for (int i = 0; i < 8; i++) send_clean();
    chk("t6_locked_start", {31'b0, locked_b}, 1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) send_bad(32'h00000001);
      chk("t6_round_unlocked", {31'b0, locked_b}, 0);
      for (int i = 0; i < 9; i++) send_clean();
      chk("t6_round_relocked", {31'b0, locked_b}, 1);
    end
    chk("t6_err_count_w16", {16'b0, err_count_a}, 20);
    chk("t6_err_count_w4_sat", {28'b0, err_count_b}, 15);
    chk("t6_bit_err_w4_sat", {28'b0, bit_err_count_b}, 15);
    chk("t6_word_count_w4_sat", {28'b0, word_count_b}, 15);
    chk("t6_bit_err_w16", {16'b0, bit_err_count_a}, 20);
    push(gen ^ 32'h00000001, 1'b1, 1'b1);
    gen = lfsr_step(gen);
    chk("t6_clear_wins_w4", {28'b0, err_count_b}, 0);
    chk("t6_clear_wins_w16", {16'b0, err_count_a}, 0);
    chk("t6_clear_err_pulse", {31'b0, err_pulse_b}, 1);
    send_bad(32'h00000003);
    chk("t6_count_after_clear", {28'b0, err_count_b}, 1);
    chk("t6_bits_after_clear", {28'b0, bit_err_count_b}, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
